// File: rtl/rshift_pkg.sv
// Shared types and helpers for the arbitrated 8-bit logical right shifter.
package rshift_pkg;
  localparam int DATA_W = 8;
  localparam int AMT_W  = 3;
  localparam int ID_MAX_W = 3;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amt;
  } req_beat_t;

  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [ID_MAX_W-1:0] id;
  } res_beat_t;

  function automatic logic [DATA_W-1:0] lsr(input req_beat_t b);
    return b.data >> b.amt;
  endfunction
endpackage

// File: rtl/rshift_arbiter_rr.sv
// Combinational round-robin pick: first requester after i_last, wrapping at NREQ.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_last,
  input  logic            i_en,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);
  logic [IDW-1:0] w_cand;

  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IDW'((int'(i_last) + k) % NREQ);
      if (!o_any && i_req[w_cand]) begin
        o_any = 1'b1;
        o_idx = w_cand;
      end
    end
    // o_any/o_idx stay valid when disabled; only the grant is gated
    if (i_en && o_any) o_gnt[o_idx] = 1'b1;
  end
endmodule

// File: rtl/rshift_arbiter.sv
// NREQ requesters share one 8-bit logical right shifter through a round-robin
// arbiter; results land in a single registered slot tagged with the winner id.
module rshift_arbiter
  import rshift_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  input  logic [NREQ*AMT_W-1:0]    req_amt,
  output logic [NREQ-1:0]          req_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [IDW-1:0]           out_id,
  input  logic                     out_ready
);
  req_beat_t [NREQ-1:0] w_beat;
  logic [NREQ-1:0]      w_gnt;
  logic [IDW-1:0]       w_idx;
  logic                 w_any, w_free, w_en, w_acc;
  logic [IDW-1:0]       r_last, r_id;
  logic [DATA_W-1:0]    r_data;
  logic                 r_valid;

  for (genvar i = 0; i < NREQ; i++) begin : g_beat
    assign w_beat[i] = '{data: req_data[i*DATA_W +: DATA_W], amt: req_amt[i*AMT_W +: AMT_W]};
  end

  // Slot frees up in the same cycle the consumer drains it, so no bubble
  assign w_free = !r_valid || out_ready;
  assign w_en   = w_free && !rst;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req  (req_valid),
    .i_last (r_last),
    .i_en   (w_en),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign w_acc     = w_en && w_any;
  assign req_ready = w_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_id    <= '0;
      r_last  <= IDW'(NREQ-1);
    end else if (w_acc) begin
      r_valid <= 1'b1;
      r_data  <= lsr(w_beat[w_idx]);
      r_id    <= w_idx;
      r_last  <= w_idx;
    end else if (w_free) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_id    = r_id;
endmodule

// File: tb/tb_rshift_arbiter.sv
// Randomized and directed bench for rshift_arbiter against a cycle-level model.
module tb_rshift_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*8-1:0]   req_data  = '0;
  logic [NREQ*3-1:0]   req_amt   = '0;
  logic [NREQ-1:0]     req_ready;
  logic                out_valid;
  logic [7:0]          out_data;
  logic [IDW-1:0]      out_id;
  logic                out_ready = 1'b1;

  rshift_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_amt(req_amt), .req_ready(req_ready), .out_valid(out_valid),
    .out_data(out_data), .out_id(out_id), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  for (genvar i = 0; i < NREQ; i++) begin : g_hold
    a_hold: assert property (@(posedge clk) disable iff (rst)
      (req_valid[i] && !req_ready[i]) ##1 req_valid[i]
        |-> ($stable(req_data[i*8 +: 8]) && $stable(req_amt[i*3 +: 3])));
  end

  int n_ok = 0, n_chk = 0;

  // reference model state
  int         m_last;
  bit         m_valid;
  logic [7:0] m_data;
  int         m_id;
  int         last_g = -1;

  task automatic model_reset();
    m_last = NREQ-1; m_valid = 1'b0; m_data = 8'h00; m_id = 0;
  endtask

  function automatic int exp_grant();
    if (rst || (m_valid && !out_ready)) return -1;
    for (int k = 1; k <= NREQ; k++)
      if (req_valid[(m_last+k) % NREQ]) return (m_last+k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    int g = exp_grant();
    return (g < 0) ? '0 : NREQ'(1 << g);
  endfunction

  task automatic tick();
    int g = exp_grant();
    @(posedge clk);
    if (rst) model_reset();
    else if (g >= 0) begin
      m_data  = 8'(int'(req_data[g*8 +: 8]) / (1 << req_amt[g*3 +: 3]));
      m_id    = g;
      m_valid = 1'b1;
      m_last  = g;
    end else if (!m_valid || out_ready) m_valid = 1'b0;
    last_g = (rst) ? -1 : g;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1; req_valid = '1;
    req_data = 32'($urandom); req_amt = 12'($urandom);
    model_reset();
    tick(); tick();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", out_valid); else n_ok++;
    n_chk++; if (out_data !== 8'h00) $display("FAIL reset_data got=%h exp=00", out_data); else n_ok++;
    n_chk++; if (out_id !== 2'd0) $display("FAIL reset_id got=%0d exp=0", out_id); else n_ok++;
    n_chk++; if (req_ready !== 4'b0000) $display("FAIL reset_ready got=%b exp=0000", req_ready); else n_ok++;
    rst = 1'b0; #1;
    n_chk++; if (req_ready !== 4'b0001) $display("FAIL reset_first_ready got=%b exp=0001", req_ready); else n_ok++;
    tick();
    n_chk++; if (out_valid !== 1'b1 || out_id !== 2'd0) $display("FAIL reset_first_grant got=%0b/%0d exp=1/0", out_valid, out_id); else n_ok++;
    n_chk++; if (out_data !== m_data) $display("FAIL reset_first_data got=%h exp=%h", out_data, m_data); else n_ok++;
  endtask

  task automatic test_single();
    req_valid = '0; tick();
    req_valid = 4'b0100; req_data[23:16] = 8'hB6; req_amt[8:6] = 3'd3; #1;
    n_chk++; if (req_ready !== 4'b0100) $display("FAIL single_ready got=%b exp=0100", req_ready); else n_ok++;
    tick();
    n_chk++; if (out_valid !== 1'b1) $display("FAIL single_valid got=%0b exp=1", out_valid); else n_ok++;
    n_chk++; if (out_data !== 8'h16) $display("FAIL single_data got=%h exp=16", out_data); else n_ok++;
    n_chk++; if (out_id !== 2'd2) $display("FAIL single_id got=%0d exp=2", out_id); else n_ok++;
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    int prev = -1;
    logic [NREQ-1:0] seen = '0;
    req_data = 32'($urandom); req_amt = 12'($urandom); req_valid = '1; out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      n_chk++; if (out_valid !== 1'b1) $display("FAIL rr_valid cyc=%0d got=%0b exp=1", c, out_valid); else n_ok++;
      n_chk++; if (out_id !== IDW'(m_id)) $display("FAIL rr_id cyc=%0d got=%0d exp=%0d", c, out_id, m_id); else n_ok++;
      n_chk++; if (out_data !== m_data) $display("FAIL rr_data cyc=%0d got=%h exp=%h", c, out_data, m_data); else n_ok++;
      if (prev >= 0) begin
        n_chk++; if (int'(out_id) != (prev+1) % NREQ) $display("FAIL rr_order cyc=%0d got=%0d exp=%0d", c, out_id, (prev+1) % NREQ); else n_ok++;
      end
      prev = int'(out_id);
      seen[out_id] = 1'b1;
      if (c % NREQ == NREQ-1) begin
        n_chk++; if (seen !== '1) $display("FAIL rr_fair cyc=%0d got=%b exp=1111", c, seen); else n_ok++;
        seen = '0;
      end
      if (last_g >= 0) begin
        req_data[last_g*8 +: 8] = 8'($urandom);
        req_amt[last_g*3 +: 3]  = 3'($urandom);
      end
    end
  endtask

  task automatic test_backpressure();
    int         f_id   = m_id;
    logic [7:0] f_data = m_data;
    out_ready = 1'b0; #1;
    for (int c = 0; c < 5; c++) begin
      n_chk++; if (req_ready !== 4'b0000) $display("FAIL bp_ready cyc=%0d got=%b exp=0000", c, req_ready); else n_ok++;
      tick();
      n_chk++; if (out_valid !== 1'b1 || out_data !== f_data || out_id !== IDW'(f_id))
        $display("FAIL bp_hold cyc=%0d got=%0b/%h/%0d exp=1/%h/%0d", c, out_valid, out_data, out_id, f_data, f_id);
      else n_ok++;
    end
    out_ready = 1'b1; #1;
    n_chk++; if (req_ready !== NREQ'(1 << ((f_id+1) % NREQ))) $display("FAIL bp_resume_ready got=%b exp=%0d", req_ready, (f_id+1) % NREQ); else n_ok++;
    tick();
    n_chk++; if (out_valid !== 1'b1 || int'(out_id) != (f_id+1) % NREQ) $display("FAIL bp_resume got=%0b/%0d exp=1/%0d", out_valid, out_id, (f_id+1) % NREQ); else n_ok++;
    n_chk++; if (out_data !== m_data) $display("FAIL bp_resume_data got=%h exp=%h", out_data, m_data); else n_ok++;
    tick();
    n_chk++; if (out_valid !== 1'b1 || int'(out_id) != (f_id+2) % NREQ) $display("FAIL bp_no_bubble got=%0b/%0d exp=1/%0d", out_valid, out_id, (f_id+2) % NREQ); else n_ok++;
  endtask

  task automatic test_shift_bounds();
    logic [7:0] td [4] = '{8'hA5, 8'h80, 8'h7F, 8'hFF};
    logic [2:0] ta [4] = '{3'd0, 3'd7, 3'd7, 3'd4};
    logic [7:0] te [4] = '{8'hA5, 8'h01, 8'h00, 8'h0F};
    req_valid = '0; out_ready = 1'b1; tick();
    for (int t = 0; t < 4; t++) begin
      req_valid = NREQ'(1 << t); req_data[t*8 +: 8] = td[t]; req_amt[t*3 +: 3] = ta[t]; #1;
      tick();
      n_chk++; if (out_data !== te[t]) $display("FAIL shift_tbl%0d got=%h exp=%h", t, out_data, te[t]); else n_ok++;
      n_chk++; if (out_data !== m_data || out_id !== IDW'(t)) $display("FAIL shift_model%0d got=%h/%0d exp=%h/%0d", t, out_data, out_id, m_data, t); else n_ok++;
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(req_valid[i] && last_g != i)) begin
          req_valid[i]         = ($urandom_range(0, 2) != 0);
          req_data[i*8 +: 8]   = 8'($urandom);
          req_amt[i*3 +: 3]    = 3'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_chk++; if (req_ready !== exp_ready()) $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, req_ready, exp_ready()); else n_ok++;
      tick();
      n_chk++; if (out_valid !== m_valid || out_data !== m_data || out_id !== IDW'(m_id))
        $display("FAIL rnd_out cyc=%0d got=%0b/%h/%0d exp=%0b/%h/%0d", c, out_valid, out_data, out_id, m_valid, m_data, m_id);
      else n_ok++;
    end
  endtask

  task automatic test_reset_mid();
    req_valid = '0; out_ready = 1'b1; tick();
    req_valid = 4'b1000; req_data[31:24] = 8'($urandom); req_amt[11:9] = 3'($urandom); #1;
    tick();
    n_chk++; if (out_valid !== 1'b1 || out_id !== 2'd3) $display("FAIL mid_pre got=%0b/%0d exp=1/3", out_valid, out_id); else n_ok++;
    req_valid = '1; req_data[23:0] = 24'($urandom); req_amt[8:0] = 9'($urandom);
    #3;
    rst = 1'b1; model_reset(); #1;
    n_chk++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_id !== 2'd0)
      $display("FAIL mid_async got=%0b/%h/%0d exp=0/00/0", out_valid, out_data, out_id);
    else n_ok++;
    n_chk++; if (req_ready !== 4'b0000) $display("FAIL mid_ready got=%b exp=0000", req_ready); else n_ok++;
    tick();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL mid_hold got=%0b exp=0", out_valid); else n_ok++;
    rst = 1'b0; #1;
    n_chk++; if (req_ready !== 4'b0001) $display("FAIL mid_first_ready got=%b exp=0001", req_ready); else n_ok++;
    tick();
    n_chk++; if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== m_data)
      $display("FAIL mid_first got=%0b/%0d/%h exp=1/0/%h", out_valid, out_id, out_data, m_data);
    else n_ok++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_shift_bounds();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
